// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the IF/EX/MW pipeline sequencer.
// Also provides the hazard-match helper used by the forwarding logic.
package pipe_ctrl_pkg;

    typedef enum logic [2:0] {
        FILL   = 3'd0,
        RUN    = 3'd1,
        DRAIN  = 3'd2,
        HALTED = 3'd3,
        STEP   = 3'd4
    } ctrl_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [4:0]  REG_X0    = 5'd0;

    // A live MW writer whose rd is a source of EX; x0 is hardwired and never matches.
    function automatic logic src_match(input logic       mw_valid,
                                       input logic       mw_wr,
                                       input logic [4:0] mw_rd,
                                       input logic [4:0] rs,
                                       input logic       rs_used);
        return mw_valid && mw_wr && (mw_rd != REG_X0) && (mw_rd == rs) && rs_used;
    endfunction

endpackage

// File: rtl/perf_cnt_bank.sv
// Four free-running wrap-around event counters sharing one synchronous clear.
// Clear takes precedence over any increment in the same cycle.
module perf_cnt_bank #(
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clr,
    input  logic [3:0]         inc,
    output logic [COUNT_W-1:0] cnt0,
    output logic [COUNT_W-1:0] cnt1,
    output logic [COUNT_W-1:0] cnt2,
    output logic [COUNT_W-1:0] cnt3
);

    localparam logic [COUNT_W-1:0] ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

    logic [COUNT_W-1:0] cnt_q [4];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (inc[i]) cnt_q[i] <= cnt_q[i] + ONE;
            end
        end
    end

    assign cnt0 = cnt_q[0];
    assign cnt1 = cnt_q[1];
    assign cnt2 = cnt_q[2];
    assign cnt3 = cnt_q[3];

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Sequencer for the 3-stage IF/EX/MW pipeline: buffer enables, flush, load-use bubble,
// MW->EX forwarding selects, debug halt/step FSM and performance counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int LOAD_USE_STALL = 1,
    parameter int COUNT_W        = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [4:0]         ex_rs1,
    input  logic [4:0]         ex_rs2,
    input  logic               ex_rs1_used,
    input  logic               ex_rs2_used,
    input  logic [4:0]         ex_rd,
    input  logic               ex_reg_wr,
    input  logic               ex_is_load,
    input  logic               br_taken,
    input  logic               halt_req,
    input  logic               step,
    input  logic               perf_clr,
    output logic               pc_en,
    output logic               ifex_en,
    output logic               ifex_flush,
    output logic               ex_kill,
    output logic               fwd_a,
    output logic               fwd_b,
    output logic               halted,
    output logic [COUNT_W-1:0] cyc_cnt,
    output logic [COUNT_W-1:0] ret_cnt,
    output logic [COUNT_W-1:0] stall_cnt,
    output logic [COUNT_W-1:0] flush_cnt
);

    ctrl_state_t state, state_nxt;

    logic       ex_valid;
    logic       mw_valid;
    logic [4:0] mw_rd;
    logic       mw_wr;
    logic       mw_ld;

    logic       hit_a;
    logic       hit_b;
    logic       stall;
    logic       br_go;
    logic [3:0] cnt_inc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= FILL;
            ex_valid <= 1'b0;
            mw_valid <= 1'b0;
            mw_rd    <= REG_X0;
            mw_wr    <= 1'b0;
            mw_ld    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (ifex_en) ex_valid <= !ifex_flush;
            mw_valid <= ex_valid && !ex_kill;
            mw_rd    <= ex_rd;
            mw_wr    <= ex_reg_wr;
            mw_ld    <= ex_is_load;
        end
    end

    always_comb begin
        state_nxt  = state;
        pc_en      = 1'b0;
        ifex_en    = 1'b0;
        ifex_flush = 1'b1;
        ex_kill    = 1'b1;
        fwd_a      = 1'b0;
        fwd_b      = 1'b0;
        stall      = 1'b0;
        br_go      = 1'b0;

        hit_a = src_match(mw_valid, mw_wr, mw_rd, ex_rs1, ex_rs1_used);
        hit_b = src_match(mw_valid, mw_wr, mw_rd, ex_rs2, ex_rs2_used);

        unique case (state)
            FILL: begin
                state_nxt = RUN;
            end

            RUN, STEP: begin
                stall = (LOAD_USE_STALL != 0) && mw_ld && (hit_a || hit_b);
                if (stall) begin
                    // Hold IF and EX, bubble into MW; the held branch redirects next cycle.
                    ifex_flush = 1'b0;
                end else begin
                    br_go   = ex_valid && br_taken;
                    fwd_a   = hit_a;
                    fwd_b   = hit_b;
                    ex_kill = !ex_valid;
                    ifex_en = 1'b1;
                    if (state == RUN && halt_req) begin
                        // EX still completes; the fetched word is dropped so PC stays at it.
                        pc_en      = br_go;
                        ifex_flush = 1'b1;
                        state_nxt  = DRAIN;
                    end else begin
                        pc_en      = 1'b1;
                        ifex_flush = br_go;
                        if (state == STEP) state_nxt = DRAIN;
                    end
                end
            end

            DRAIN: begin
                // EX is only occupied here after a single step; let it finish (and redirect).
                ifex_en   = 1'b1;
                ex_kill   = !ex_valid;
                fwd_a     = hit_a;
                fwd_b     = hit_b;
                pc_en     = ex_valid && br_taken;
                state_nxt = HALTED;
            end

            HALTED: begin
                ifex_flush = 1'b0;
                if (!halt_req)  state_nxt = RUN;
                else if (step)  state_nxt = STEP;
            end

            default: begin
                state_nxt = FILL;
            end
        endcase
    end

    assign halted  = (state == HALTED);
    assign cnt_inc = {br_go, stall, mw_valid, (state != HALTED)};

    perf_cnt_bank #(
        .COUNT_W (COUNT_W)
    ) u_perf (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (perf_clr),
        .inc     (cnt_inc),
        .cnt0    (cyc_cnt),
        .cnt1    (ret_cnt),
        .cnt2    (stall_cnt),
        .cnt3    (flush_cnt)
    );

endmodule
